// File: rtl/fifo_burst_drain.sv
// fifo_burst_drain: read-side burst consumer that drains a FIFO into a valid/ready stream
// Waits for a full burst in the FIFO. It then reads exactly BURST words through fiford.
// The registered memory data is buffered in a 2-entry in-order buffer. That buffer
// presents the words downstream and marks the final word of each burst with out_last.
// Optional feature: define FIFO_BURST_DRAIN_TIMEOUT_EN to force a partial burst after
// TIMEOUT idle cycles while the FIFO holds fewer than BURST words.
// Ports:
//   clkr      read-domain clock
//   rst       asynchronous active-low reset
//   notempty  FIFO non-empty flag
//   fifolen   FIFO occupancy in words
//   rddata    memory read data, valid the cycle after fiford
//   fiford    read request (combinational)
//   out_data  stream data
//   out_valid stream data valid
//   out_ready stream accept
//   out_last  final word of a burst
//   busy      burst in progress or words still in flight
module fifo_burst_drain #(
  parameter int DATABIT = 8,
  parameter int ADDRBIT = 5,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clkr,
  input  logic               rst,
  input  logic               notempty,
  input  logic [ADDRBIT:0]   fifolen,
  input  logic [DATABIT-1:0] rddata,
  output logic               fiford,
  output logic [DATABIT-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy
);
  localparam logic [ADDRBIT:0] BL = (ADDRBIT+1)'(BURST);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state, state_nx;
  logic [ADDRBIT:0] rem, rem_nx;
  logic pending, pend_last, pop;
  logic [1:0] occ, occ_ap;
  logic [2:0] lvl;
  logic [DATABIT-1:0] d0, d1;
  logic l0, l1;
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
  logic [7:0] cnt, cnt_nx;
  logic idle_wait, part;
`endif
  assign out_valid = occ != 2'd0;
  assign out_data  = d0;
  assign out_last  = l0;
  assign busy      = state != IDLE || occ != 2'd0 || pending;
  assign pop       = out_valid && out_ready;
  assign occ_ap    = occ - {1'b0, pop};
  always_comb begin
    // Level counts buffered words plus the read in flight, net of this cycle's pop,
    // so a new read is only issued when its data is guaranteed a free slot.
    lvl = {1'b0, occ} + {2'b0, pending} - {2'b0, pop};
    fiford = rst && state == DRAIN && notempty && rem != '0 && lvl < 3'd2;
    state_nx = state;
    rem_nx = rem;
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
    idle_wait = state == IDLE && notempty && fifolen < BL && fifolen != '0;
    part = idle_wait && cnt == 8'(TIMEOUT - 1);
    cnt_nx = idle_wait && !part ? cnt + 8'd1 : 8'd0;
`endif
    if (state == IDLE) begin
      state_nx = fifolen >= BL ? DRAIN : IDLE;
      rem_nx = fifolen >= BL ? BL : rem;
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
      if (part) begin
        state_nx = DRAIN;
        rem_nx = fifolen;
      end
`endif
    end else if (fiford) begin
      rem_nx = rem - 1'b1;
      state_nx = rem == (ADDRBIT+1)'(1) ? IDLE : DRAIN;
    end
  end
  always_ff @(posedge clkr or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rem <= '0;
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
      cnt <= 8'd0;
`endif
    end else begin
      state <= state_nx;
      rem <= rem_nx;
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
      cnt <= cnt_nx;
`endif
    end
  end
  // Head is d0. A pop shifts d1 forward, and the arriving word lands in the first
  // free slot after that pop, so order is kept on simultaneous push and pop.
  always_ff @(posedge clkr or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
      pend_last <= 1'b0;
      occ <= 2'd0;
      d0 <= '0;
      d1 <= '0;
      l0 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      pending <= fiford;
      pend_last <= fiford && rem == (ADDRBIT+1)'(1);
      occ <= occ_ap + {1'b0, pending};
      if (pop) begin
        d0 <= d1;
        l0 <= l1;
      end
      if (pending && occ_ap == 2'd0) begin
        d0 <= rddata;
        l0 <= pend_last;
      end
      if (pending && occ_ap == 2'd1) begin
        d1 <= rddata;
        l1 <= pend_last;
      end
    end
  end
endmodule

// File: tb/tb_fifo_burst_drain.sv
// tb_fifo_burst_drain: scoreboard bench with a FIFO/memory model and randomized traffic
module tb_fifo_burst_drain;
  localparam int DB = 8, AB = 5, BL = 4;
  logic clkr = 0, rst = 1, notempty = 0, out_ready = 0;
  logic fiford, out_valid, out_last, busy;
  logic [AB:0] fifolen = '0;
  logic [DB-1:0] rddata = '0, out_data;
  always #5 clkr = ~clkr;

  fifo_burst_drain #(.DATABIT(DB), .ADDRBIT(AB), .BURST(BL), .TIMEOUT(15)) dut (
    .clkr(clkr), .rst(rst), .notempty(notempty), .fifolen(fifolen), .rddata(rddata),
    .fiford(fiford), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy)
  );

  int errors = 0, checks = 0;
  logic [DB-1:0] q[$];
  logic [DB:0] exp_q[$];
  int wcnt = 0, outst = 0;
  logic [DB-1:0] next_rd = '0;
  logic rd_s, vld_s, bsy_s;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // One clock cycle: FIFO writes, inputs driven after the falling edge, then the read request is sampled.
  task automatic cycle(input int nwr, input bit rdy);
    logic [DB-1:0] w;
    @(negedge clkr);
    rddata = next_rd;
    for (int i = 0; i < nwr; i++) begin
      if (q.size() < 32) begin
        w = DB'($urandom);
        q.push_back(w);
        exp_q.push_back({w, wcnt % BL == BL - 1});
        wcnt++;
      end
    end
    fifolen = (AB+1)'(q.size());
    notempty = q.size() != 0;
    out_ready = rdy;
    #1;
    rd_s = fiford;
    vld_s = out_valid;
    bsy_s = busy;
    if (fiford) begin
      chk("read_only_when_nonempty", int'(q.size() != 0), 1);
      if (q.size() != 0) begin
        next_rd = q.pop_front();
        outst++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clkr);
    rst = 0;
    #1;
    chk("rst_fiford", fiford, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    q.delete();
    exp_q.delete();
    outst = 0;
    wcnt = 0;
    fifolen = '0;
    notempty = 0;
    @(negedge clkr);
    rst = 1;
  endtask

  bit stall = 0;
  logic [DB:0] held, mon_e;
  always @(negedge clkr) begin
    #2;
    if (!rst) stall = 0;
    else begin
      if (stall) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_word_held", {out_data, out_last}, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          chk("word_data_last", {out_data, out_last}, mon_e);
        end
        outst--;
        chk("in_flight_le2", int'(outst <= 2), 1);
      end
      stall = out_valid && !out_ready;
      held = {out_data, out_last};
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] rdv, vv, bv;
    int n, nv, first;
    #2 rst = 0;
    #1;
    chk("reset_fiford", fiford, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_last", out_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_data", out_data, 0);
    repeat (2) cycle(0, 0);
    rst = 1;
    cycle(0, 0);
    rdv = '0; vv = '0; bv = '0;
    for (int c = 0; c < 12; c++) begin
      cycle(c == 0 ? 4 : 0, 1);
      rdv[c] = rd_s; vv[c] = vld_s; bv[c] = bsy_s;
    end
    chk("t1_fiford_pattern", rdv[11:0], 12'h01E);
    chk("t1_valid_pattern", vv[11:0], 12'h078);
    chk("t1_busy_pattern", bv[11:0], 12'h07E);
    n = 0;
    for (int c = 0; c < 10; c++) begin
      cycle(c == 0 ? 4 : 0, 0);
      n += rd_s;
    end
    chk("t4_reads_while_stalled", n, 2);
    chk("t4_valid_while_stalled", vld_s, 1);
    for (int c = 0; c < 10; c++) begin
      cycle(0, 1);
      n += rd_s;
    end
    chk("t4_total_reads", n, 4);
    chk("t4_all_delivered", exp_q.size(), 0);
    rdv = '0;
    for (int c = 0; c < 16; c++) begin
      cycle(c == 0 ? 8 : 0, 1);
      rdv[c] = rd_s;
    end
    chk("t5_two_bursts_pattern", rdv[11:0], 12'h3DE);
    chk("t5_all_delivered", exp_q.size(), 0);
    cycle(4, 1);
    cycle(0, 1);
    cycle(0, 1);
    do_reset();
    n = 0; nv = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(0, 1);
      n += rd_s; nv += vld_s;
    end
    chk("t6_no_reads_after_reset", n, 0);
    chk("t6_no_stale_word", nv, 0);
    n = 0; nv = 0; first = -1;
    for (int c = 0; c < 100; c++) begin
      cycle(c == 0 ? 3 : 0, 1);
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
      if (c == 0) begin
        exp_q[2] = exp_q[2] | 1;
        wcnt = 0;
      end
`endif
      if (rd_s && first < 0) first = c;
      n += rd_s; nv += vld_s;
    end
`ifdef FIFO_BURST_DRAIN_TIMEOUT_EN
    chk("t3_partial_reads", n, 3);
    chk("t3_timeout_cycle", first, 15);
    chk("t3_partial_delivered", exp_q.size(), 0);
`else
    chk("t3_no_reads_short_fifo", n, 0);
    chk("t3_no_valid_short_fifo", nv, 0);
    do_reset();
`endif
    for (int c = 0; c < 300; c++)
      cycle(($urandom % 6 == 0 && q.size() <= 28) ? 4 : 0, $urandom % 4 != 0);
    for (int c = 0; c < 80; c++) cycle(0, 1);
    chk("final_scoreboard_empty", exp_q.size(), 0);
    chk("final_fifo_empty", q.size(), 0);
    chk("final_in_flight", outst, 0);
    chk("final_busy", busy, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_burst_drain.md
# fifo_burst_drain

Read-side consumer for the dual-clock FIFO controller, running in the read clock domain. Waits until the FIFO holds a full burst, drains exactly that many words via `fiford`, captures the memory's registered read data, and presents it downstream on a valid/ready stream with an end-of-burst marker. A 2-entry output buffer absorbs the one-cycle memory read latency and downstream backpressure without losing throughput.

## Interface
- `DATABIT`, 8: width of a FIFO word.
- `ADDRBIT`, 5: FIFO address width; `fifolen` is `ADDRBIT+1` bits.
- `BURST`, 4: words per burst, 1..2^ADDRBIT.
- `TIMEOUT`, 15: idle cycles before a partial burst is forced (only with the macro below), 1..255.

- `clkr` in 1: read-domain clock; all state on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `notempty` in 1: FIFO controller non-empty flag.
- `fifolen` in ADDRBIT+1: FIFO occupancy in words.
- `rddata` in DATABIT: memory read data, valid the cycle after `fiford`.
- `fiford` out 1: read request to FIFO controller (combinational).
- `out_data` out DATABIT: stream data.
- `out_valid` out 1: stream data valid.
- `out_ready` in 1: downstream accepts when high with `out_valid`.
- `out_last` out 1: marks the final word of a burst.
- `busy` out 1: high whenever state is not IDLE or buffer/pipeline is non-empty.

## Operation
- Reset: state IDLE, remaining count 0, pending 0, buffer occupancy 0; `out_valid`, `out_last`, `busy`, `fiford` = 0, `out_data` = 0.
- States: IDLE, BURST.
- IDLE -> BURST when `fifolen >= BURST`; load remaining = BURST.
- In BURST: `fiford = notempty && remaining != 0 && (occ + pending - pop) < 2`, where `pop = out_valid && out_ready`, `pending` = `fiford` registered, `occ` = buffer entries (0..2).
- Each `fiford` cycle decrements remaining (width ADDRBIT+1, never below 0).
- BURST -> IDLE on the edge where remaining becomes 0; pipeline/buffer continue draining in IDLE; new burst may start next cycle.
- Pending read: `rddata` written into buffer tail at next edge, tagged last = (it was the remaining==1 read).
- Buffer is in-order 2-entry; head drives `out_data`/`out_last`; `out_valid = occ != 0`.
- Push and pop same edge: occupancy unchanged, order preserved.
- `fiford` never asserted when `notempty` low; burst never exceeds words present at start.

## Timing
- IDLE with `fifolen >= BURST` in cycle T: state BURST at T+1, `fiford` high in T+1.
- `fiford` in cycle C: data captured at end of C+1; `out_valid` high from C+2 (2-cycle latency).
- With `out_ready` held high: one word per cycle, BURST words in BURST consecutive cycles, `out_last` on the last.
- `out_valid && !out_ready`: `out_data`, `out_last` held stable; `fiford` throttles so occupancy never exceeds 2; no word dropped.
- Reset asserted mid-burst: all state cleared immediately, in-flight words discarded, `fiford` low asynchronously.

## Configuration
- `FIFO_BURST_DRAIN_TIMEOUT_EN` defined: an 8-bit idle counter runs in IDLE while `notempty && fifolen < BURST`, clears otherwise; on reaching TIMEOUT, enter BURST with remaining = `fifolen` (partial burst, `out_last` on its final word); counter cleared on entry.
- Not defined: no counter; IDLE waits indefinitely for `fifolen >= BURST`.

## Test plan
- Reset, then `fifolen`=4, `notempty`=1, `out_ready`=1, BURST=4: `fiford` high 4 consecutive cycles starting one cycle after; 4 words out back-to-back, `out_last` on 4th only; `busy` falls after last accept.
- `fifolen`=3, BURST=4, macro undefined: `fiford` stays 0 for 100 cycles, `out_valid` 0.
- Same with macro defined, TIMEOUT=15: after 15 idle cycles a 3-word burst issues, `out_last` on 3rd word.
- `out_ready`=0 during burst of 4: exactly 2 reads issued, `out_valid`=1 with first word held; release `out_ready`: remaining 2 read, all 4 words delivered in order.
- `fifolen`=8 sustained, `out_ready`=1: two back-to-back bursts, `out_last` on words 4 and 8, no idle gap beyond one cycle between bursts.
- Assert `rst` low after 2 of 4 reads: outputs 0 same cycle; after release, IDLE, `out_valid`=0, no stale word emitted.
